// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared types, bit-order constants and counter sizing for the serial deserializer
package serdes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    // Bit-order encoding shared with the shift-register transmitter.
    localparam bit BIT_ORDER_MSB = 1'b1;
    localparam bit BIT_ORDER_LSB = 1'b0;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// rtl/deser_bit_counter.sv - frame bit counter; terminal count WIDTH, or WIDTH+1 with PARITY_CHECK_EN
module deser_bit_counter
    import serdes_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic strobe_i,
    output logic last_o
);

`ifdef PARITY_CHECK_EN
    localparam int TERM = WIDTH + 1;
`else
    localparam int TERM = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(TERM - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // A strobe coincident with start is bit 0, so the count resumes at 1.
    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = strobe_i ? CW'(1) : '0;
        end else if (strobe_i) begin
            count_d = (count_q == LAST_IDX) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == LAST_IDX);

endmodule

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - framed serial-to-parallel receiver with valid/ready output; optional PARITY_CHECK_EN
module serial_deserializer
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = BIT_ORDER_MSB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             ser_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             parity_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             accept;
    logic             last_bit;
    logic             complete;
    logic             shift_en;
    logic             drop;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;

    deser_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (cnt_width(WIDTH))
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (frame_start),
        .strobe_i (accept),
        .last_o   (last_bit)
    );

    assign accept   = ser_en && (frame_start || (state_q == RECV));
    assign complete = accept && !frame_start && last_bit;

    always_comb begin
        if (MSB_FIRST == BIT_ORDER_MSB) begin
            shifted = {sreg_q[WIDTH-2:0], ser_in};
        end else begin
            shifted = {ser_in, sreg_q[WIDTH-1:1]};
        end
    end

`ifdef PARITY_CHECK_EN
    logic perr_q, perr_d;

    // The parity bit never enters the shift register; the word is already complete.
    assign word     = sreg_q;
    assign shift_en = accept && !complete;
`else
    assign word     = shifted;
    assign shift_en = accept;
`endif

    always_comb begin
        state_d = state_q;
        sreg_d  = shift_en ? shifted : sreg_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        drop    = 1'b0;
`ifdef PARITY_CHECK_EN
        perr_d  = perr_q;
`endif
        if (frame_start) begin
            state_d = RECV;
        end
        if (complete) begin
            if (!valid_q || data_ready) begin
                dout_d  = word;
                valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                perr_d  = ^{sreg_q, ser_in};
`endif
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
        ovr_d = (ovr_q && !overrun_clr) || drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - MSB-first and LSB-first deserializers against a bit-queue reference model
module tb_serial_deserializer;

    localparam int W = 8;
`ifdef PARITY_CHECK_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk;
    logic         rst;
    logic         frame_start;
    logic         ser_en;
    logic         ser_in;
    logic         data_ready;
    logic         overrun_clr;
    logic [W-1:0] dout_m, dout_l;
    logic         dv_m, dv_l;
    logic         ov_m, ov_l;
    logic         pe_m, pe_l;

    int checks   = 0;
    int failures = 0;

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .ser_en      (ser_en),
        .ser_in      (ser_in),
        .data_out    (dout_m),
        .data_valid  (dv_m),
        .data_ready  (data_ready),
        .overrun     (ov_m),
        .overrun_clr (overrun_clr),
        .parity_err  (pe_m)
    );

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .ser_en      (ser_en),
        .ser_in      (ser_in),
        .data_out    (dout_l),
        .data_valid  (dv_l),
        .data_ready  (data_ready),
        .overrun     (ov_l),
        .overrun_clr (overrun_clr),
        .parity_err  (pe_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits collected since the last frame_start, word formed when a frame is full.
    bit           m_bits[$];
    bit           m_in_frame;
    logic [W-1:0] m_msb, m_lsb;
    logic         m_valid, m_ov, m_perr;

    function automatic void model_reset();
        m_bits.delete();
        m_in_frame = 1'b0;
        m_msb = '0;
        m_lsb = '0;
        m_valid = 1'b0;
        m_ov = 1'b0;
        m_perr = 1'b0;
    endfunction

    function automatic void model_update();
        bit           done = 1'b0;
        bit           set_ov = 1'b0;
        logic [W-1:0] wm = '0;
        logic [W-1:0] wl = '0;
        logic         pe = 1'b0;
        if (frame_start) begin
            m_bits.delete();
            m_in_frame = 1'b1;
            if (ser_en) m_bits.push_back(ser_in);
        end else if (m_in_frame && ser_en) begin
            m_bits.push_back(ser_in);
            if (m_bits.size() == FRAME) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) begin
                    wm = (wm << 1) | W'(m_bits[i]);
                    wl[i] = m_bits[i];
                end
`ifdef PARITY_CHECK_EN
                for (int i = 0; i < FRAME; i++) pe = pe ^ m_bits[i];
`endif
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || data_ready) begin
                m_msb = wm;
                m_lsb = wl;
                m_perr = pe;
                m_valid = 1'b1;
            end else begin
                set_ov = 1'b1;
            end
        end else if (m_valid && data_ready) begin
            m_valid = 1'b0;
        end
        if (overrun_clr) m_ov = 1'b0;
        if (set_ov) m_ov = 1'b1;
    endfunction

    task automatic step(input logic fs, input logic en, input logic b, input logic rdy, input logic clr);
        frame_start = fs;
        ser_en      = en;
        ser_in      = b;
        data_ready  = rdy;
        overrun_clr = clr;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        frame_start = 1'b0;
        ser_en      = 1'b0;
        ser_in      = 1'b0;
        data_ready  = 1'b0;
        overrun_clr = 1'b0;
        rst = 1'b1;
        model_reset();
        #4;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends one frame of w (MSB first on the wire) and counts cycles with data_valid high.
    task automatic send_word(input logic [W-1:0] w, input logic fs, input logic rdy_body,
                             input logic rdy_last, input logic flip, output int vcnt);
        vcnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            logic b;
            if (k < W) b = w[W-1-k];
            else       b = (^w) ^ flip;
            step(fs && (k == 0), 1'b1, b, (k == FRAME - 1) ? rdy_last : rdy_body, 1'b0);
            if (dv_m === 1'b1) vcnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_start = 1'b0; ser_en = 1'b0; ser_in = 1'b0; data_ready = 1'b0; overrun_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({dv_m, dv_l} !== 2'b00) begin failures++; $display("FAIL reset_valid got %b expected 00", {dv_m, dv_l}); end
        checks++; if ({dout_m, dout_l} !== '0) begin failures++; $display("FAIL reset_data got %h/%h expected 0", dout_m, dout_l); end
        checks++; if ({ov_m, ov_l, pe_m, pe_l} !== 4'b0) begin failures++; $display("FAIL reset_flags got %b expected 0000", {ov_m, ov_l, pe_m, pe_l}); end
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (dv_m !== 1'b0) begin failures++; $display("FAIL idle_ignores_ser_en got %b expected 0", dv_m); end
    endtask

    task automatic test_bit_order();
        int vc;
        send_word(8'h1E, 1'b1, 1'b1, 1'b1, 1'b0, vc);
        checks++; if (dout_m !== 8'h1E) begin failures++; $display("FAIL msb_first got %h expected 1e", dout_m); end
        checks++; if (dout_l !== 8'h78) begin failures++; $display("FAIL lsb_first got %h expected 78", dout_l); end
        checks++; if (vc !== 1) begin failures++; $display("FAIL valid_at_last_bit got %0d expected 1", vc); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if ({dv_m, dv_l} !== 2'b00) begin failures++; $display("FAIL valid_one_cycle got %b expected 00", {dv_m, dv_l}); end
    endtask

    task automatic test_overrun();
        int vc;
        send_word(8'h1E, 1'b1, 1'b0, 1'b0, 1'b0, vc);
        send_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, vc);
        checks++; if (dout_m !== 8'h1E || dout_l !== 8'h78) begin failures++; $display("FAIL overrun_hold got %h/%h expected 1e/78", dout_m, dout_l); end
        checks++; if ({dv_m, ov_m, ov_l} !== 3'b111) begin failures++; $display("FAIL overrun_set got %b expected 111", {dv_m, ov_m, ov_l}); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if ({ov_m, ov_l} !== 2'b00) begin failures++; $display("FAIL overrun_clr got %b expected 00", {ov_m, ov_l}); end
        checks++; if (dv_m !== 1'b1 || dout_m !== 8'h1E) begin failures++; $display("FAIL clr_keeps_word got %b/%h expected 1/1e", dv_m, dout_m); end
    endtask

    task automatic test_back_to_back();
        int vc;
        send_word(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, vc);
        checks++; if (vc !== FRAME) begin failures++; $display("FAIL b2b_valid_cycles got %0d expected %0d", vc, FRAME); end
        checks++; if (dout_m !== 8'hA5 || dout_l !== 8'hA5) begin failures++; $display("FAIL b2b_data got %h/%h expected a5/a5", dout_m, dout_l); end
        checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL b2b_no_overrun got %b expected 0", ov_m); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (dv_m !== 1'b0) begin failures++; $display("FAIL b2b_accept got %b expected 0", dv_m); end
    endtask

    task automatic test_resync();
        int vc;
        int total = 0;
        for (int k = 0; k < 5; k++) begin
            step(k == 0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            if (dv_m === 1'b1) total++;
        end
        send_word(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, vc);
        total += vc;
        checks++; if (total !== 1) begin failures++; $display("FAIL resync_words got %0d expected 1", total); end
        checks++; if (dout_m !== 8'hA5 || dv_m !== 1'b1) begin failures++; $display("FAIL resync_data got %h/%b expected a5/1", dout_m, dv_m); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_word();
        int vc;
        int stray = 0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        do_reset();
        checks++; if (dv_m !== 1'b0 || dout_m !== 8'h00) begin failures++; $display("FAIL rst_mid got %b/%h expected 0/00", dv_m, dout_m); end
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            if (dv_m === 1'b1 || dv_l === 1'b1) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL rst_no_frame got %0d words expected 0", stray); end
        send_word(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, vc);
        checks++; if (dout_m !== 8'h3C || dout_l !== 8'h3C || dv_m !== 1'b1) begin failures++; $display("FAIL rst_refrme got %h/%h/%b expected 3c/3c/1", dout_m, dout_l, dv_m); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        int vc;
        send_word(8'h1E, 1'b1, 1'b1, 1'b1, 1'b0, vc);
        checks++; if (pe_m !== 1'b0 || dout_m !== 8'h1E) begin failures++; $display("FAIL parity_ok got %b/%h expected 0/1e", pe_m, dout_m); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'h1E, 1'b0, 1'b1, 1'b1, 1'b1, vc);
        checks++; if (pe_m !== 1'b1 || pe_l !== 1'b1 || dout_m !== 8'h1E) begin failures++; $display("FAIL parity_bad got %b/%h expected 1/1e", pe_m, dout_m); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step((i == 0) || ($urandom_range(0, 39) == 0),
                 $urandom_range(0, 9) < 7,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 29) == 0);
            checks++;
            if (dv_m !== m_valid || dout_m !== m_msb || ov_m !== m_ov || pe_m !== m_perr ||
                dv_l !== m_valid || dout_l !== m_lsb || ov_l !== m_ov || pe_l !== m_perr) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cycle %0d got v%b d%h/%h o%b p%b expected v%b d%h/%h o%b p%b",
                             i, dv_m, dout_m, dout_l, ov_m, pe_m, m_valid, m_msb, m_lsb, m_ov, m_perr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_overrun();
        test_back_to_back();
        test_resync();
        test_reset_mid_word();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
